// File: rtl/param_sr_counter.sv
// param_sr_counter: start/stop cycle counter with programmable terminal, wrap/saturate modes, tc pulse, sticky overflow
// Ports: clk_i, rst_ni (async active-low); start_i/stop_i run control; clear_i sync clear;
//   load_i/load_val_i parallel load; term_wr_i/term_val_i terminal write;
//   count_o, running_o, done_o, tc_o, overflow_o all registered.
module param_sr_counter #(
  parameter int              WIDTH    = 16,
  parameter bit              MODE     = 1'b0,
  parameter logic [WIDTH-1:0] TERM_RST = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             term_wr_i,
  input  logic [WIDTH-1:0] term_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             done_o,
  output logic             tc_o,
  output logic             overflow_o
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, term_q, term_d;
  logic tc_q, tc_d, ovf_q, ovf_d;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    term_d  = term_wr_i ? term_val_i : term_q;
    if (clear_i) begin
      state_d = IDLE;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      count_d = load_val_i;
      state_d = state_q == DONE ? PAUSED : state_q;
    end else if (stop_i) begin
      state_d = state_q == RUN ? PAUSED : state_q;
    end else if (start_i && (state_q == IDLE || state_q == PAUSED)) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (count_q == term_q) begin
        tc_d = 1'b1;
        if (MODE) state_d = DONE;
        else begin
          count_d = '0;
          ovf_d   = 1'b1;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
        ovf_d   = ovf_q | (&count_q);
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      term_q  <= TERM_RST;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end
  assign count_o    = count_q;
  assign running_o  = state_q == RUN;
  assign done_o     = state_q == DONE;
  assign tc_o       = tc_q;
  assign overflow_o = ovf_q;
endmodule
